// File: rtl/peripheral_pkg.sv
// Shared definitions for the peripheral stream responder: register map,
// STATUS/CONTROL bit positions and the bus-side FSM state encoding.
package peripheral_pkg;

    localparam logic [2:0] ADDR_DATA     = 3'd0;
    localparam logic [2:0] ADDR_STATUS   = 3'd1;
    localparam logic [2:0] ADDR_RX_COUNT = 3'd2;
    localparam logic [2:0] ADDR_TX_COUNT = 3'd3;
    localparam logic [2:0] ADDR_CONTROL  = 3'd4;

    localparam int ST_RX_EMPTY    = 0;
    localparam int ST_RX_FULL     = 1;
    localparam int ST_TX_EMPTY    = 2;
    localparam int ST_TX_FULL     = 3;
    localparam int ST_TIMEOUT_ERR = 4;

    localparam int CTL_FLUSH_RX = 0;
    localparam int CTL_FLUSH_TX = 1;
    localparam int CTL_CLR_ERR  = 2;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_WAIT_RD = 2'd1,
        S_WAIT_WR = 2'd2,
        S_ACK     = 2'd3
    } state_e;

endpackage

// File: rtl/peripheral_stream_responder_if.sv
// Peripheral bus request/acknowledge signals; the master holds req, wen,
// addr and wdata stable until it sees per_ack.
interface peripheral_stream_responder_if;
    logic        per_req;
    logic        per_wen;
    logic [2:0]  per_addr;
    logic [15:0] per_wdata;
    logic [15:0] per_rdata;
    logic        per_ack;

    modport master (output per_req, per_wen, per_addr, per_wdata,
                    input  per_rdata, per_ack);
    modport slave  (input  per_req, per_wen, per_addr, per_wdata,
                    output per_rdata, per_ack);
endinterface

// File: rtl/sync_fifo.sv
// Single-clock show-ahead FIFO with occupancy count and a flush that
// overrides any push or pop requested in the same cycle.
module sync_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   srst,
    input  logic                   push_i,
    input  logic [WIDTH-1:0]       wdata_i,
    input  logic                   pop_i,
    input  logic                   flush_i,
    output logic [WIDTH-1:0]       head_o,
    output logic [$clog2(DEPTH):0] count_o,
    output logic                   full_o,
    output logic                   empty_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic             do_push, do_pop;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];

    assign do_push = push_i && !full_o && !flush_i;
    assign do_pop  = pop_i && !empty_o && !flush_i;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    // Pointers are exactly AW bits so they wrap on their own at DEPTH.
    always_ff @(posedge clk) begin
        if (srst || flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            if (do_push && !do_pop)      count_q <= count_q + CW'(1);
            else if (do_pop && !do_push) count_q <= count_q - CW'(1);
        end
    end
endmodule

// File: rtl/peripheral_stream_responder.sv
// Peripheral-bus slave fronting an RX/TX FIFO pair; DATA accesses stall in
// wait states on empty RX / full TX, bounded by an optional timeout.
module peripheral_stream_responder
    import peripheral_pkg::*;
#(
    parameter int DEPTH   = 16,
    parameter int TIMEOUT = 1024
) (
    input  logic                          clock,
    input  logic                          reset,
    peripheral_stream_responder_if.slave  bus,
    input  logic [15:0]                   rx_data,
    input  logic                          rx_valid,
    output logic                          rx_ready,
    output logic [15:0]                   tx_data,
    output logic                          tx_valid,
    input  logic                          tx_ready
);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0] TMAX = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    state_e         state_q, state_d;
    logic [TW-1:0]  wait_cnt_q, wait_cnt_d;
    logic [15:0]    rdata_q, rdata_d;
    logic           err_q;
    logic           err_set, err_clr;

    logic [15:0]    rx_head, tx_head, reg_rdata;
    logic [CW-1:0]  rx_count, tx_count;
    logic           rx_full, rx_empty, tx_full, tx_empty;
    logic           rx_pop, tx_push, flush_rx, flush_tx;
    logic           is_data, ctl_write;

    sync_fifo #(.WIDTH(16), .DEPTH(DEPTH)) u_rx_fifo (
        .clk(clock), .srst(reset),
        .push_i(rx_valid && rx_ready), .wdata_i(rx_data),
        .pop_i(rx_pop), .flush_i(flush_rx),
        .head_o(rx_head), .count_o(rx_count),
        .full_o(rx_full), .empty_o(rx_empty)
    );

    sync_fifo #(.WIDTH(16), .DEPTH(DEPTH)) u_tx_fifo (
        .clk(clock), .srst(reset),
        .push_i(tx_push), .wdata_i(bus.per_wdata),
        .pop_i(tx_valid && tx_ready), .flush_i(flush_tx),
        .head_o(tx_head), .count_o(tx_count),
        .full_o(tx_full), .empty_o(tx_empty)
    );

    assign rx_ready      = !rx_full;
    assign tx_valid      = !tx_empty;
    assign tx_data       = tx_head;
    assign bus.per_ack   = (state_q == S_ACK);
    assign bus.per_rdata = rdata_q;

    assign is_data   = (bus.per_addr == ADDR_DATA);
    assign ctl_write = bus.per_req && bus.per_wen && (bus.per_addr == ADDR_CONTROL);

    always_comb begin
        reg_rdata = '0;
        case (bus.per_addr)
            ADDR_STATUS: begin
                reg_rdata[ST_RX_EMPTY]    = rx_empty;
                reg_rdata[ST_RX_FULL]     = rx_full;
                reg_rdata[ST_TX_EMPTY]    = tx_empty;
                reg_rdata[ST_TX_FULL]     = tx_full;
                reg_rdata[ST_TIMEOUT_ERR] = err_q;
            end
            ADDR_RX_COUNT: reg_rdata = 16'(rx_count);
            ADDR_TX_COUNT: reg_rdata = 16'(tx_count);
            default:       reg_rdata = '0;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        rdata_d    = rdata_q;
        rx_pop     = 1'b0;
        tx_push    = 1'b0;
        flush_rx   = 1'b0;
        flush_tx   = 1'b0;
        err_set    = 1'b0;
        err_clr    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.per_req) begin
                    wait_cnt_d = '0;
                    if (is_data && !bus.per_wen) begin
                        if (rx_empty) begin
                            state_d = S_WAIT_RD;
                        end else begin
                            rx_pop  = 1'b1;
                            rdata_d = rx_head;
                            state_d = S_ACK;
                        end
                    end else if (is_data && bus.per_wen) begin
                        if (tx_full) begin
                            state_d = S_WAIT_WR;
                        end else begin
                            tx_push = 1'b1;
                            rdata_d = '0;
                            state_d = S_ACK;
                        end
                    end else begin
                        rdata_d = bus.per_wen ? 16'h0000 : reg_rdata;
                        state_d = S_ACK;
                    end
                end
            end
            S_WAIT_RD: begin
                if (!rx_empty) begin
                    rx_pop  = 1'b1;
                    rdata_d = rx_head;
                    state_d = S_ACK;
                end else if (TIMEOUT != 0 && wait_cnt_q == TMAX) begin
                    rdata_d = '0;
                    err_set = 1'b1;
                    state_d = S_ACK;
                end else if (TIMEOUT != 0) begin
                    wait_cnt_d = wait_cnt_q + TW'(1);
                end
            end
            S_WAIT_WR: begin
                if (!tx_full) begin
                    tx_push = 1'b1;
                    rdata_d = '0;
                    state_d = S_ACK;
                end else if (TIMEOUT != 0 && wait_cnt_q == TMAX) begin
                    rdata_d = '0;
                    err_set = 1'b1;
                    state_d = S_ACK;
                end else if (TIMEOUT != 0) begin
                    wait_cnt_d = wait_cnt_q + TW'(1);
                end
            end
            S_ACK: begin
                // CONTROL side effects land here, while the master still holds the write.
                state_d = S_IDLE;
                if (ctl_write) begin
                    flush_rx = bus.per_wdata[CTL_FLUSH_RX];
                    flush_tx = bus.per_wdata[CTL_FLUSH_TX];
                    err_clr  = bus.per_wdata[CTL_CLR_ERR];
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= S_IDLE;
            wait_cnt_q <= '0;
            rdata_q    <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            rdata_q    <= rdata_d;
            err_q      <= err_set | (err_q & ~err_clr);
        end
    end
endmodule

// File: tb/tb_peripheral_stream_responder.sv
// Directed bench for peripheral_stream_responder (DEPTH=16, TIMEOUT=8) with
// hand-computed expected latencies and read data.
module tb_peripheral_stream_responder;
    import peripheral_pkg::*;

    logic        clock;
    logic        reset;
    logic [15:0] rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic [15:0] tx_data;
    logic        tx_valid;
    logic        tx_ready;

    int pass_cnt = 0;
    int total_cnt = 0;

    peripheral_stream_responder_if bus_if ();

    peripheral_stream_responder #(.DEPTH(16), .TIMEOUT(8)) dut (
        .clock    (clock),
        .reset    (reset),
        .bus      (bus_if),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_ready (rx_ready),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Issues one bus transaction starting in the current cycle; lat is the
    // number of cycles from the request cycle to the ack cycle.
    task automatic bus_xfer(input logic wen, input logic [2:0] addr, input logic [15:0] wdata,
                            output logic [15:0] rdata, output int lat);
        bus_if.per_wen   = wen;
        bus_if.per_addr  = addr;
        bus_if.per_wdata = wdata;
        bus_if.per_req   = 1'b1;
        lat = 0;
        do begin
            @(posedge clock); #1;
            lat++;
        end while (!bus_if.per_ack && lat < 64);
        chk("ack_seen", 32'(bus_if.per_ack), 32'd1);
        rdata = bus_if.per_rdata;
        @(posedge clock); #1;
        bus_if.per_req = 1'b0;
        chk("ack_one_cycle", 32'(bus_if.per_ack), 32'd0);
    endtask

    task automatic rx_push(input logic [15:0] w);
        rx_data  = w;
        rx_valid = 1'b1;
        @(posedge clock); #1;
        rx_valid = 1'b0;
    endtask

    logic [15:0] rd;
    int          lat;

    initial begin
        reset = 1'b1;
        rx_data = '0; rx_valid = 1'b0; tx_ready = 1'b0;
        bus_if.per_req = 1'b0; bus_if.per_wen = 1'b0;
        bus_if.per_addr = '0; bus_if.per_wdata = '0;
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;

        chk("rst_ack", 32'(bus_if.per_ack), 32'd0);
        chk("rst_rdata", 32'(bus_if.per_rdata), 32'd0);
        chk("rst_rx_ready", 32'(rx_ready), 32'd1);
        chk("rst_tx_valid", 32'(tx_valid), 32'd0);

        bus_xfer(1'b0, ADDR_STATUS, 16'h0, rd, lat);
        chk("status0_lat", 32'(lat), 32'd1);
        chk("status0", 32'(rd), 32'h0005);
        bus_xfer(1'b0, ADDR_RX_COUNT, 16'h0, rd, lat);
        chk("rxcnt0", 32'(rd), 32'd0);

        rx_push(16'h00A1); rx_push(16'h00A2); rx_push(16'h00A3);
        bus_xfer(1'b0, ADDR_RX_COUNT, 16'h0, rd, lat);
        chk("rxcnt3", 32'(rd), 32'd3);
        for (int i = 0; i < 3; i++) begin
            bus_xfer(1'b0, ADDR_DATA, 16'h0, rd, lat);
            chk("rd_fifo_lat", 32'(lat), 32'd1);
            chk("rd_fifo_data", 32'(rd), 32'h00A1 + 32'(i));
        end
        bus_xfer(1'b0, ADDR_STATUS, 16'h0, rd, lat);
        chk("status_rx_drained", 32'(rd), 32'h0005);

        // Read on empty RX; device word arrives 5 cycles after the request.
        fork
            bus_xfer(1'b0, ADDR_DATA, 16'h0, rd, lat);
            begin
                repeat (5) @(posedge clock);
                #1 rx_push(16'hBEEF);
            end
        join
        chk("wait_rd_lat", 32'(lat), 32'd7);
        chk("wait_rd_data", 32'(rd), 32'hBEEF);
        bus_xfer(1'b0, ADDR_STATUS, 16'h0, rd, lat);
        chk("status_no_err", 32'(rd), 32'h0005);

        // Park one RX word so the STATUS values below have rx_empty clear.
        rx_push(16'h1234);
        for (int i = 0; i < 16; i++) begin
            bus_xfer(1'b1, ADDR_DATA, 16'h0100 + 16'(i), rd, lat);
            chk("wr_lat", 32'(lat), 32'd1);
        end
        chk("tx_valid_full", 32'(tx_valid), 32'd1);
        chk("tx_head", 32'(tx_data), 32'h0100);
        bus_xfer(1'b0, ADDR_STATUS, 16'h0, rd, lat);
        chk("status_tx_full", 32'(rd), 32'h0008);
        bus_xfer(1'b1, ADDR_DATA, 16'hDEAD, rd, lat);
        chk("timeout_lat", 32'(lat), 32'd9);
        bus_xfer(1'b0, ADDR_STATUS, 16'h0, rd, lat);
        chk("status_timeout", 32'(rd), 32'h0018);
        bus_xfer(1'b0, ADDR_TX_COUNT, 16'h0, rd, lat);
        chk("txcnt16", 32'(rd), 32'd16);
        bus_xfer(1'b1, ADDR_CONTROL, 16'h0004, rd, lat);
        bus_xfer(1'b0, ADDR_STATUS, 16'h0, rd, lat);
        chk("status_err_clr", 32'(rd), 32'h0008);
        bus_xfer(1'b0, ADDR_CONTROL, 16'h0, rd, lat);
        chk("control_reads0", 32'(rd), 32'h0000);

        // Drain TX: words come out in order, the timed-out word never appears.
        tx_ready = 1'b1;
        for (int k = 0; k < 16; k++) begin
            chk("tx_drain", 32'(tx_data), 32'h0100 + 32'(k));
            @(posedge clock); #1;
        end
        tx_ready = 1'b0;
        chk("tx_empty_after", 32'(tx_valid), 32'd0);

        // Fill RX to DEPTH, then flush it while the device keeps offering a word.
        rx_valid = 1'b1;
        for (int i = 0; i < 15; i++) begin
            rx_data = 16'h2000 + 16'(i);
            @(posedge clock); #1;
        end
        rx_data = 16'hCAFE;
        chk("rx_full_ready", 32'(rx_ready), 32'd0);
        bus_xfer(1'b0, ADDR_STATUS, 16'h0, rd, lat);
        chk("status_rx_full", 32'(rd), 32'h0006);
        bus_xfer(1'b1, ADDR_CONTROL, 16'h0001, rd, lat);
        rx_valid = 1'b0;
        chk("flush_rx_ready", 32'(rx_ready), 32'd1);
        bus_xfer(1'b0, ADDR_RX_COUNT, 16'h0, rd, lat);
        chk("rxcnt_flushed", 32'(rd), 32'd0);
        bus_xfer(1'b0, ADDR_STATUS, 16'h0, rd, lat);
        chk("status_flushed", 32'(rd), 32'h0005);

        // Reset during WAIT_RD abandons the read without an ack.
        bus_if.per_wen = 1'b0; bus_if.per_addr = ADDR_DATA; bus_if.per_req = 1'b1;
        @(posedge clock); #1;
        chk("wait_no_ack0", 32'(bus_if.per_ack), 32'd0);
        @(posedge clock); #1;
        reset = 1'b1;
        @(posedge clock); #1;
        chk("wait_no_ack1", 32'(bus_if.per_ack), 32'd0);
        reset = 1'b0; bus_if.per_req = 1'b0;
        @(posedge clock); #1;
        chk("wait_no_ack2", 32'(bus_if.per_ack), 32'd0);
        bus_xfer(1'b0, ADDR_STATUS, 16'h0, rd, lat);
        chk("post_rst_lat", 32'(lat), 32'd1);
        chk("post_rst_status", 32'(rd), 32'h0005);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
